// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one RV32I ALU between two requesters, with a one-deep result stage.
// Optional performance counters are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arbiter #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,

`ifdef ALU_ARB_PERF_EN
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_conflict,
`endif

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp_rd,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSll  = 4'b0001,
    OpSlt  = 4'b0010,
    OpSltu = 4'b0011,
    OpXor  = 4'b0100,
    OpSrl  = 4'b0101,
    OpOr   = 4'b0110,
    OpAnd  = 4'b0111,
    OpSub  = 4'b1000,
    OpSra  = 4'b1101
  } alu_op_e;

  // Result stage state
  logic             full_q, full_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [31:0]      rd_q, rd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  // Arbitration
  logic             gnt_valid;
  logic             gnt_sel;
  logic             owner_ready;
  logic             can_accept;
  logic             drain;
  logic             xfer;

  // Selected request
  logic [3:0]       sel_op;
  logic [31:0]      sel_rs1;
  logic [31:0]      sel_rs2;
  logic [TAG_W-1:0] sel_tag;
  logic [4:0]       shamt;

  // ALU output
  logic [31:0]      alu_rd;
  logic             alu_err;

  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    // On a tie the port that did not win last time goes next.
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_q;
    end else begin
      gnt_sel = req1_valid;
    end
  end

  always_comb begin
    owner_ready = owner_q ? resp1_ready : resp0_ready;
    drain       = full_q & owner_ready;
    can_accept  = ~full_q | owner_ready;
    xfer        = can_accept & gnt_valid;
    req0_ready  = can_accept & gnt_valid & ~gnt_sel;
    req1_ready  = can_accept & gnt_valid & gnt_sel;
  end

  always_comb begin
    sel_op  = gnt_sel ? req1_op  : req0_op;
    sel_rs1 = gnt_sel ? req1_rs1 : req0_rs1;
    sel_rs2 = gnt_sel ? req1_rs2 : req0_rs2;
    sel_tag = gnt_sel ? req1_tag : req0_tag;
    shamt   = sel_rs2[4:0];
  end

  always_comb begin
    alu_rd  = 32'h0;
    alu_err = 1'b0;
    case (sel_op)
      OpAdd:   alu_rd = sel_rs1 + sel_rs2;
      OpSub:   alu_rd = sel_rs1 - sel_rs2;
      OpSll:   alu_rd = sel_rs1 << shamt;
      OpSlt:   alu_rd = {31'h0, $signed(sel_rs1) < $signed(sel_rs2)};
      OpSltu:  alu_rd = {31'h0, sel_rs1 < sel_rs2};
      OpXor:   alu_rd = sel_rs1 ^ sel_rs2;
      OpSrl:   alu_rd = sel_rs1 >> shamt;
      OpSra:   alu_rd = $unsigned($signed(sel_rs1) >>> shamt);
      OpOr:    alu_rd = sel_rs1 | sel_rs2;
      OpAnd:   alu_rd = sel_rs1 & sel_rs2;
      default: begin
        alu_rd  = 32'h0;
        alu_err = 1'b1;
      end
    endcase
  end

  // A transfer overwrites the stage even when it drains on the same edge.
  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (xfer) begin
      full_d  = 1'b1;
      owner_d = gnt_sel;
      last_d  = gnt_sel;
      rd_d    = alu_rd;
      tag_d   = sel_tag;
      err_d   = alu_err;
    end else if (drain) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 32'h0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign resp0_valid = full_q & ~owner_q;
  assign resp1_valid = full_q & owner_q;
  assign resp_rd     = rd_q;
  assign resp_tag    = tag_q;
  assign resp_err    = err_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] grant0_q, grant0_d;
  logic [CNT_W-1:0] grant1_q, grant1_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  // Counters saturate at all-ones.
  always_comb begin
    grant0_d   = grant0_q;
    grant1_d   = grant1_q;
    conflict_d = conflict_q;
    if (xfer && !gnt_sel && (grant0_q != '1)) begin
      grant0_d = grant0_q + 1'b1;
    end
    if (xfer && gnt_sel && (grant1_q != '1)) begin
      grant1_d = grant1_q + 1'b1;
    end
    if (req0_valid && req1_valid && (conflict_q != '1)) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      conflict_q <= conflict_d;
    end
  end

  assign perf_grant0   = grant0_q;
  assign perf_grant1   = grant1_q;
  assign perf_conflict = conflict_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one RV32I integer ALU datapath (add/sub/sll/slt/sltu/xor/srl/sra/or/and) between two requesters, e.g. the main issue slot and the address/branch helper.
- Round-robin arbitration with valid/ready handshakes on request and response sides.
- One-deep registered result stage: 1-cycle latency, full throughput of one op per cycle.

Parameters:
- TAG_W, 4, width of requester-supplied tag returned with the result.
- CNT_W, 16, width of performance counters (used only with ALU_ARB_PERF_EN).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request valid, port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready.
- req0_op / req1_op  in  4  operation {funct7[5], funct3}.
- req0_rs1 / req1_rs1  in  32  operand 1.
- req0_rs2 / req1_rs2  in  32  operand 2.
- req0_tag / req1_tag  in  TAG_W  tag echoed on response.
- resp0_valid / resp1_valid  out  1  result valid, for port 0 / port 1 (never both).
- resp0_ready / resp1_ready  in  1  requester consumes result.
- resp_rd  out  32  shared result bus.
- resp_tag  out  TAG_W  echoed tag.
- resp_err  out  1  illegal op flag.
- perf_grant0 / perf_grant1  out  CNT_W  accepted-request counts (ALU_ARB_PERF_EN only).
- perf_conflict  out  CNT_W  cycles with both requests valid (ALU_ARB_PERF_EN only).

Behaviour:
- Reset (rst_n low, async): full=0, owner=0, last=1 (port 0 wins the first tie), resp_rd=0, resp_tag=0, resp_err=0, resp0/1_valid=0, perf counters 0.
- Result stage state: full, owner. respN_valid = full && owner==N.
- can_accept = !full || (owner's respN_valid && respN_ready).
- Grant, combinational:
  - Only one reqN_valid: grant N.
  - Both valid: grant the port != last.
  - Neither valid: no grant.
- reqN_ready = can_accept && grant==N. The non-granted port's ready is 0. Ready may depend on valid; requesters must not make valid depend on ready.
- Transfer (valid && ready) at an edge:
  - Compute the ALU result from the granted port's op/rs1/rs2.
  - Register resp_rd, resp_tag, resp_err; owner<=granted, full<=1, last<=granted.
- Latency: response visible the cycle after the transfer.
- Drain without a new transfer: full<=0. Data outputs hold their last value.
- Simultaneous drain + transfer: stage overwritten with the new result, full stays 1. Back-to-back, one result per cycle.
- Backpressure: while full and the owner is not ready, both req ready=0 and the response outputs remain stable.
- Op decode:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt (signed), 0011 sltu, 0100 xor, 0101 srl, 1101 sra (arithmetic), 0110 or, 0111 and.
  - Shift amount = rs2[4:0]; rs2[31:5] ignored.
  - Add/sub wrap modulo 2^32.
  - slt/sltu produce 0x00000001 or 0x00000000.
- Illegal op (any other code): resp_rd=0, resp_err=1; still a normal handshake. resp_err=0 for legal ops.
- Reset mid-operation: pending result discarded; no response is ever issued for it.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- Defined:
  - perf_grant0/1 increment on each transfer from the respective port.
  - perf_conflict increments each cycle both reqN_valid are high.
  - All three saturate at all-ones; cleared only by reset.
- Undefined: the three perf ports and their counter logic are absent from the module.

Test Plan:
- Single request: req0 add rs1=0x00000005 rs2=0x00000003 tag=2 -> next cycle resp0_valid=1, resp_rd=0x00000008, resp_tag=2, resp_err=0, resp1_valid=0.
- Contention: both ports valid every cycle, resp ready held 1 -> grants 0,1,0,1,...; one response per cycle; with ALU_ARB_PERF_EN after 8 cycles perf_grant0=4, perf_grant1=4, perf_conflict=8.
- Backpressure: result for port 1 held with resp1_ready=0 for 3 cycles -> req0_ready=req1_ready=0 and resp_rd stable. Raise resp1_ready with req0 pending -> drain and accept on the same edge; resp0_valid appears the next cycle.
- Op corners:
  - sra 0x80000000 by rs2=0x00000024 -> 0xF8000000.
  - srl same operands -> 0x08000000.
  - slt 0xFFFFFFFF,0x00000001 -> 1; sltu same -> 0.
  - sub 0x00000000-0x00000001 -> 0xFFFFFFFF.
  - add 0xFFFFFFFF+1 -> 0.
- Illegal op 4'b1001 -> resp_rd=0x00000000, resp_err=1, handshake completes normally.
- Async reset while resp0_valid=1 -> resp0_valid=0 immediately without a clock edge; after release, the first tie grants port 0 and the perf counters read 0.
